// File: rtl/wbc_arbiter.sv
// Round-robin arbiter for the WISHBONE control bus. A grant lasts until the owning master drops
// cyc, and one GAP cycle follows every grant. A stalled strobe is ended by a one-cycle timeout error.
module wbc_arbiter #(
  parameter int          NMASTERS = 4,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NMASTERS-1:0] cyc_i,
  input  logic                stb_i,
  input  logic                ack_i,
  input  logic                err_i,
  input  logic                rty_i,
  output logic [NMASTERS-1:0] gnt_o,
  output logic [1:0]          gnt_idx_o,
  output logic                gnt_valid_o,
  output logic                timeout_err_o,
  output logic [7:0]          timeout_count_o,
  output logic [15:0]         debug_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } state_t;

  state_t              state, state_nxt;
  logic [1:0]          ptr, ptr_nxt;
  logic [7:0]          tcnt, tcnt_nxt;
  logic [NMASTERS-1:0] gnt_nxt;
  logic [1:0]          idx_nxt;
  logic                vld_nxt;
  logic                terr_nxt;
  logic [7:0]          tcount_nxt;
  logic                sel_found;
  logic [1:0]          sel_idx;
  logic                term;

  function automatic logic [1:0] wrap_idx(input logic [1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NMASTERS) s = s - NMASTERS;
    return 2'(s);
  endfunction

  assign term = ack_i | err_i | rty_i;

  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = 2'd0;
    state_nxt  = state;
    ptr_nxt    = ptr;
    tcnt_nxt   = 8'd0;
    gnt_nxt    = gnt_o;
    idx_nxt    = gnt_idx_o;
    vld_nxt    = gnt_valid_o;
    terr_nxt   = 1'b0;
    tcount_nxt = timeout_count_o;

    for (int i = 0; i < NMASTERS; i++) begin
      if (!sel_found && cyc_i[wrap_idx(ptr, i)]) begin
        sel_found = 1'b1;
        sel_idx   = wrap_idx(ptr, i);
      end
    end

    case (state)
      IDLE: begin
        if (sel_found) begin
          state_nxt        = GRANT;
          gnt_nxt          = '0;
          gnt_nxt[sel_idx] = 1'b1;
          idx_nxt          = sel_idx;
          vld_nxt          = 1'b1;
        end
      end
      GRANT: begin
        // Losing cyc wins over a pending timeout: the master is already leaving.
        if (!cyc_i[gnt_idx_o]) begin
          state_nxt = GAP;
          gnt_nxt   = '0;
          vld_nxt   = 1'b0;
          ptr_nxt   = wrap_idx(gnt_idx_o, 1);
        end else if (stb_i && !term) begin
          if (tcnt == TIMEOUT) begin
            terr_nxt = 1'b1;
            if (timeout_count_o != 8'hFF) tcount_nxt = timeout_count_o + 8'd1;
          end else begin
            tcnt_nxt = tcnt + 8'd1;
          end
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= IDLE;
      ptr             <= 2'd0;
      tcnt            <= 8'd0;
      gnt_o           <= '0;
      gnt_idx_o       <= 2'd0;
      gnt_valid_o     <= 1'b0;
      timeout_err_o   <= 1'b0;
      timeout_count_o <= 8'd0;
    end else begin
      state           <= state_nxt;
      ptr             <= ptr_nxt;
      tcnt            <= tcnt_nxt;
      gnt_o           <= gnt_nxt;
      gnt_idx_o       <= idx_nxt;
      gnt_valid_o     <= vld_nxt;
      timeout_err_o   <= terr_nxt;
      timeout_count_o <= tcount_nxt;
    end
  end

  assign debug_o = {state, ptr, gnt_idx_o, tcnt, timeout_err_o, gnt_valid_o};

endmodule

// File: tb/tb_wbc_arbiter.sv
// Directed bench for wbc_arbiter: expected values are queued as stimulus is applied and
// compared when the DUT outputs settle after the following clock edge.
module tb_wbc_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] cyc = 4'b0000;
  logic       stb = 1'b0, ack = 1'b0, err = 1'b0, rty = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gidx;
  logic       gvld, terr;
  logic [7:0] tcount;
  logic [15:0] dbg;

  logic [3:0] s_cyc = 4'b0000;
  logic       s_stb = 1'b0;
  logic       s_zero = 1'b0;
  logic [3:0] s_gnt;
  logic [1:0] s_gidx;
  logic       s_gvld, s_terr;
  logic [7:0] s_tcount;
  logic [15:0] s_dbg;

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  wbc_arbiter #(.NMASTERS(4), .TIMEOUT(8'd255)) dut (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .ack_i(ack), .err_i(err), .rty_i(rty),
    .gnt_o(gnt), .gnt_idx_o(gidx), .gnt_valid_o(gvld), .timeout_err_o(terr),
    .timeout_count_o(tcount), .debug_o(dbg)
  );

  // Short timeout so counter saturation is reachable in a few hundred cycles.
  wbc_arbiter #(.NMASTERS(4), .TIMEOUT(8'd2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .cyc_i(s_cyc), .stb_i(s_stb), .ack_i(s_zero), .err_i(s_zero),
    .rty_i(s_zero), .gnt_o(s_gnt), .gnt_idx_o(s_gidx), .gnt_valid_o(s_gvld),
    .timeout_err_o(s_terr), .timeout_count_o(s_tcount), .debug_o(s_dbg)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string t, input logic [31:0] e);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  initial begin
    // Asynchronous reset with no clock edge yet seen.
    #2 rst = 1'b1;
    #1;
    push("rst_gnt", 32'h0);    pop_check(32'(gnt));
    push("rst_gvld", 32'h0);   pop_check(32'(gvld));
    push("rst_tcount", 32'h0); pop_check(32'(tcount));
    push("rst_dbg", 32'h0);    pop_check(32'(dbg));
    step();
    step();
    rst = 1'b0;

    // Round robin with all four requesting.
    cyc = 4'b1111;
    push("rr_g0", 32'h1); step(); pop_check(32'(gnt));
    push("rr_g0_idx", 32'h0); pop_check(32'(gidx));
    push("rr_g0_state", 32'h1); pop_check(32'(dbg[15:14]));
    cyc = 4'b1110;
    push("rr_gap_gnt", 32'h0); step(); pop_check(32'(gnt));
    push("rr_gap_vld", 32'h0); pop_check(32'(gvld));
    push("rr_gap_idx_held", 32'h0); pop_check(32'(gidx));
    push("rr_gap_state", 32'h2); pop_check(32'(dbg[15:14]));
    push("rr_idle_gnt", 32'h0); step(); pop_check(32'(gnt));
    push("rr_g1", 32'h2); step(); pop_check(32'(gnt));
    cyc = 4'b1100;
    step(); step();
    push("rr_g2", 32'h4); step(); pop_check(32'(gnt));
    cyc = 4'b1000;
    step(); step();
    push("rr_g3", 32'h8); step(); pop_check(32'(gnt));
    push("rr_g3_idx", 32'h3); pop_check(32'(gidx));
    cyc = 4'b0111;
    step(); step();
    push("rr_wrap_g0", 32'h1); step(); pop_check(32'(gnt));
    push("rr_wrap_hold", 32'h1); step(); pop_check(32'(gnt));

    // Drop everything; a request present only during GAP is never granted.
    cyc = 4'b0000;
    step();
    cyc = 4'b0100;
    step();
    cyc = 4'b0000;
    push("ghost_gnt", 32'h0); step(); pop_check(32'(gnt));
    push("ghost_vld", 32'h0); step(); pop_check(32'(gvld));

    // Master 2 keeps the bus across three acks while master 0 waits.
    cyc = 4'b0100;
    push("blk_g2", 32'h4); step(); pop_check(32'(gnt));
    cyc = 4'b0101;
    stb = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ack = 1'b1;
      push("blk_hold_ack", 32'h4); step(); pop_check(32'(gnt));
      ack = 1'b0;
      push("blk_hold_noack", 32'h4); step(); pop_check(32'(gnt));
    end
    cyc = 4'b0001;
    stb = 1'b0;
    push("blk_gap", 32'h0); step(); pop_check(32'(gnt));
    step();
    push("blk_g0", 32'h1); step(); pop_check(32'(gnt));

    // Timeout after 256 unterminated strobes.
    stb = 1'b1;
    repeat (255) step();
    push("to_tcnt_255", 32'd255); pop_check(32'(dbg[9:2]));
    push("to_no_err_yet", 32'h0); pop_check(32'(terr));
    push("to_err", 32'h1); step(); pop_check(32'(terr));
    push("to_count1", 32'h1); pop_check(32'(tcount));
    push("to_tcnt_clr", 32'h0); pop_check(32'(dbg[9:2]));
    push("to_gnt_kept", 32'h1); pop_check(32'(gnt));
    push("to_err_1cyc", 32'h0); step(); pop_check(32'(terr));
    push("to_tcnt_restart", 32'h1); pop_check(32'(dbg[9:2]));

    // Ack at tcnt == TIMEOUT wins over the timeout.
    repeat (254) step();
    push("ack_tcnt_255", 32'd255); pop_check(32'(dbg[9:2]));
    ack = 1'b1;
    push("ack_no_err", 32'h0); step(); pop_check(32'(terr));
    ack = 1'b0;
    push("ack_count_same", 32'h1); pop_check(32'(tcount));
    push("ack_tcnt_clr", 32'h0); pop_check(32'(dbg[9:2]));

    // Retry and idle strobe also clear the counter.
    repeat (5) step();
    push("rty_pre", 32'd5); pop_check(32'(dbg[9:2]));
    rty = 1'b1;
    push("rty_clr", 32'h0); step(); pop_check(32'(dbg[9:2]));
    rty = 1'b0;
    repeat (3) step();
    stb = 1'b0;
    push("stb_low_clr", 32'h0); step(); pop_check(32'(dbg[9:2]));
    stb = 1'b1;

    // Dropping cyc at tcnt == TIMEOUT leaves without an error.
    repeat (255) step();
    push("drop_tcnt_255", 32'd255); pop_check(32'(dbg[9:2]));
    cyc = 4'b0000;
    push("drop_no_err", 32'h0); step(); pop_check(32'(terr));
    push("drop_gnt", 32'h0); pop_check(32'(gnt));
    push("drop_count_same", 32'h1); pop_check(32'(tcount));
    push("drop_state_gap", 32'h2); pop_check(32'(dbg[15:14]));
    push("drop_ptr", 32'h1); pop_check(32'(dbg[13:12]));

    // Asynchronous reset in mid-grant.
    stb = 1'b0;
    cyc = 4'b1000;
    step();
    push("pre_rst_g3", 32'h8); step(); pop_check(32'(gnt));
    #3 rst = 1'b1;
    #1;
    push("async_rst_gnt", 32'h0); pop_check(32'(gnt));
    push("async_rst_vld", 32'h0); pop_check(32'(gvld));
    push("async_rst_count", 32'h0); pop_check(32'(tcount));
    push("async_rst_dbg", 32'h0); pop_check(32'(dbg));
    step();
    rst = 1'b0;
    cyc = 4'b1010;
    push("post_rst_g1", 32'h2); step(); pop_check(32'(gnt));
    push("post_rst_idx", 32'h1); pop_check(32'(gidx));

    // Saturation of the timeout counter (TIMEOUT=2: one timeout every 3 cycles).
    s_cyc = 4'b0001;
    s_stb = 1'b1;
    push("sat_grant", 32'h1); step(); pop_check(32'(s_gnt));
    for (int i = 0; i < 900; i++) begin
      step();
      if (s_terr) pulses++;
      if (i == 299) begin
        push("sat_count_100", 32'd100); pop_check(32'(s_tcount));
      end
    end
    push("sat_pulses", 32'd300); pop_check(32'(pulses));
    push("sat_count_ff", 32'hFF); pop_check(32'(s_tcount));
    push("sat_gnt_kept", 32'h1); pop_check(32'(s_gnt));

    if (exp_q.size() != 0) begin
      miscompares++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
